// File: rtl/ahb_switch_button_in.sv
// rtl/ahb_switch_button_in.sv - AHB-Lite slave for board switches and buttons.
// Synchronised switches, debounced buttons, sticky W1C press flags and a level IRQ.
module ahb_switch_button_in #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_SWITCHES    = 16,
    parameter int NUM_BUTTONS     = 2
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    input  logic [NUM_SWITCHES-1:0] Switches,
    input  logic [NUM_BUTTONS-1:0]  Buttons,
    output logic                    IRQ
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SWITCHES-1:0] sw_meta_q, sw_sync_q;
    logic [NUM_BUTTONS-1:0]  btn_meta_q, btn_sync_q;
    logic [NUM_BUTTONS-1:0]  deb_q, deb_d;
    logic [NUM_BUTTONS-1:0]  press_q, press_d;
    logic [NUM_BUTTONS-1:0]  irq_en_q, irq_en_d;
    logic [CW-1:0]           cnt_q [NUM_BUTTONS];
    logic [CW-1:0]           cnt_d [NUM_BUTTONS];
    logic                    dp_valid_q, dp_valid_d;
    logic                    dp_write_q, dp_write_d;
    logic [1:0]              dp_addr_q, dp_addr_d;
    logic                    irq_q;
    logic                    wr_en;
    logic [NUM_BUTTONS-1:0]  w1c_mask;
    logic [31:0]             rdata;

    wire unused_ok = &{1'b0, HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0],
                       HWDATA[31:NUM_BUTTONS]};

    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            if (btn_sync_q[b] == deb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_MAX) begin
                deb_d[b] = btn_sync_q[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end

        wr_en    = dp_valid_q & dp_write_q;
        w1c_mask = (wr_en && dp_addr_q == 2'd2) ? HWDATA[NUM_BUTTONS-1:0] : '0;
        // A rising debounced edge in the same cycle as a W1C keeps the flag set.
        press_d  = (press_q & ~w1c_mask) | (deb_d & ~deb_q);
        irq_en_d = (wr_en && dp_addr_q == 2'd3) ? HWDATA[NUM_BUTTONS-1:0] : irq_en_q;

        dp_valid_d = HSEL & HREADY & HTRANS[1];
        dp_write_d = dp_valid_d & HWRITE;
        dp_addr_d  = dp_valid_d ? HADDR[3:2] : 2'd0;

        rdata = '0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                2'd0:    rdata[NUM_SWITCHES-1:0] = sw_sync_q;
                2'd1:    rdata[NUM_BUTTONS-1:0]  = deb_q;
                2'd2:    rdata[NUM_BUTTONS-1:0]  = press_q;
                default: rdata[NUM_BUTTONS-1:0]  = irq_en_q;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            deb_q      <= '0;
            press_q    <= '0;
            irq_en_q   <= '0;
            for (int b = 0; b < NUM_BUTTONS; b++) cnt_q[b] <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
            irq_q      <= 1'b0;
        end else begin
            sw_meta_q  <= Switches;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= Buttons;
            btn_sync_q <= btn_meta_q;
            deb_q      <= deb_d;
            press_q    <= press_d;
            irq_en_q   <= irq_en_d;
            for (int b = 0; b < NUM_BUTTONS; b++) cnt_q[b] <= cnt_d[b];
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            irq_q      <= |(press_q & irq_en_q);
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = irq_q;

endmodule
